// File: rtl/dff_link_arb_pkg.sv
// Shared state type and sizing helpers for the dff_link_arbiter slice.
package dff_link_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        FLUSH
    } arb_state_t;

    // Requester index width; never collapses to zero bits.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dff_link_arbiter_if.sv
// Requester, shared-link and tagged-output bundle of dff_link_arbiter.
interface dff_link_arbiter_if #(parameter int N_REQ = 4);
    import dff_link_arb_pkg::*;

    localparam int ID_W = id_width(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] data_in;
    logic [N_REQ-1:0] grant;
    logic             link_in;
    logic             link_out;
    logic             out_valid;
    logic             out_bit;
    logic [ID_W-1:0]  out_id;
    logic             busy;

    modport master (
        output req, data_in, link_out,
        input  grant, link_in, out_valid, out_bit, out_id, busy
    );

    modport slave (
        input  req, data_in, link_out,
        output grant, link_in, out_valid, out_bit, out_id, busy
    );

endinterface

// File: rtl/dff_link_arb_rr.sv
// Combinational round-robin picker: first requester after ptr, wrapping, ptr itself last.
module dff_link_arb_rr #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]                              req,
    input  logic [dff_link_arb_pkg::id_width(N_REQ)-1:0]  ptr,
    output logic [N_REQ-1:0]                              pick,
    output logic                                          any
);
    import dff_link_arb_pkg::*;

    localparam int ID_W = id_width(N_REQ);

    logic             found;
    logic [ID_W-1:0]  idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = ID_W'((int'(ptr) + i) % N_REQ);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/dff_link_arbiter.sv
// Round-robin burst arbiter for one shared DFF delay line, with a shadow {valid,id} pipeline.
// Optional DFF_LINK_ARB_FLUSH_EN: drain the link for DEPTH idle cycles after every burst.
module dff_link_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DEPTH     = 4,
    parameter int BURST_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dff_link_arbiter_if.slave    bus
);
    import dff_link_arb_pkg::*;

    localparam int ID_W  = id_width(N_REQ);
    localparam int CNT_W = $clog2(max_int(BURST_MAX, DEPTH) + 1);

    arb_state_t        state;
    logic [N_REQ-1:0]  grant_q;
    logic [CNT_W-1:0]  cnt;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   gidx;
    logic [ID_W-1:0]   rr_ptr;
    logic [N_REQ-1:0]  rr_pick;
    logic              rr_any;
    logic              xfer;
    logic [DEPTH-1:0]  sh_valid;
    logic [ID_W-1:0]   sh_id [DEPTH];

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) gidx = ID_W'(i);
        end
    end

    assign xfer   = |(grant_q & bus.req);
    // At a burst end the search starts just past the current owner.
    assign rr_ptr = (state == GRANT) ? gidx : ptr;

    dff_link_arb_rr #(.N_REQ(N_REQ)) u_rr (
        .req  (bus.req),
        .ptr  (rr_ptr),
        .pick (rr_pick),
        .any  (rr_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant_q <= '0;
            cnt     <= '0;
            ptr     <= ID_W'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (rr_any) begin
                        grant_q <= rr_pick;
                        cnt     <= '0;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (xfer && cnt != CNT_W'(BURST_MAX - 1)) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        ptr <= gidx;
                        cnt <= '0;
`ifdef DFF_LINK_ARB_FLUSH_EN
                        grant_q <= '0;
                        state   <= FLUSH;
`else
                        if (rr_any) begin
                            grant_q <= rr_pick;
                        end else begin
                            grant_q <= '0;
                            state   <= IDLE;
                        end
`endif
                    end
                end
`ifdef DFF_LINK_ARB_FLUSH_EN
                FLUSH: begin
                    if (cnt == CNT_W'(DEPTH - 1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    grant_q <= '0;
                    cnt     <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Shadow pipeline mirrors the link stage-for-stage so ids line up with link_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_valid <= '0;
            for (int i = 0; i < DEPTH; i++) sh_id[i] <= '0;
        end else begin
            sh_valid[0] <= xfer;
            sh_id[0]    <= xfer ? gidx : '0;
            for (int i = 1; i < DEPTH; i++) begin
                sh_valid[i] <= sh_valid[i-1];
                sh_id[i]    <= sh_id[i-1];
            end
        end
    end

    assign bus.grant     = grant_q;
    assign bus.link_in   = |(grant_q & bus.data_in);
    assign bus.out_valid = sh_valid[DEPTH-1];
    assign bus.out_bit   = bus.link_out & sh_valid[DEPTH-1];
    assign bus.out_id    = sh_id[DEPTH-1];
    assign bus.busy      = (state != IDLE) || (|sh_valid);

endmodule

// File: tb/tb_dff_link_arbiter.sv
// Self-checking bench for dff_link_arbiter: directed table, reset corners and randomized model checks.
module tb_dff_link_arbiter;
    import dff_link_arb_pkg::*;

    localparam int N_REQ     = 4;
    localparam int DEPTH     = 4;
    localparam int BURST_MAX = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dff_link_arbiter_if #(.N_REQ(N_REQ)) bus ();

    dff_link_arbiter #(
        .N_REQ     (N_REQ),
        .DEPTH     (DEPTH),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stand-in for the shared DFF link, reset by the same net as the arbiter.
    logic [DEPTH-1:0] linkSr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) linkSr <= '0;
        else        linkSr <= {linkSr[DEPTH-2:0], bus.link_in};
    end
    assign bus.link_out = linkSr[DEPTH-1];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit v;
        int id;
        bit b;
    } pipe_t;

    int    owner;
    int    burstCount;
    int    rrPtr;
    int    flushLeft;
    pipe_t pipe[$];

    typedef struct {
        logic [3:0] req;
        logic [3:0] data;
        logic [3:0] expGrant;
        logic       expValid;
        logic       expBit;
        logic [1:0] expId;
        logic       expBusy;
    } vec_t;

    vec_t vecs[16];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rrPick(input logic [3:0] r, input int from);
        for (int i = 1; i <= N_REQ; i++) begin
            int c;
            c = (from + i) % N_REQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic modelReset();
        pipe_t e;
        owner      = -1;
        burstCount = 0;
        rrPtr      = N_REQ - 1;
        flushLeft  = 0;
        pipe.delete();
        e.v  = 1'b0;
        e.id = 0;
        e.b  = 1'b0;
        for (int i = 0; i < DEPTH; i++) pipe.push_back(e);
    endtask

    // One rising edge of the arbiter, described by ownership and a bit queue.
    task automatic modelStep(input logic [3:0] r, input logic [3:0] d);
        pipe_t e;
        bit    xfer;
        xfer = (owner >= 0) && r[owner];
        e.v  = xfer;
        e.id = xfer ? owner : 0;
        e.b  = xfer ? d[owner] : 1'b0;
        pipe.push_back(e);
        void'(pipe.pop_front());
        if (flushLeft > 0) begin
            flushLeft--;
        end else if (owner < 0) begin
            if (r != 4'b0000) begin
                owner      = rrPick(r, rrPtr);
                burstCount = 0;
            end
        end else begin
            if (xfer) burstCount++;
            if (!xfer || burstCount == BURST_MAX) begin
                rrPtr      = owner;
                burstCount = 0;
`ifdef DFF_LINK_ARB_FLUSH_EN
                owner     = -1;
                flushLeft = DEPTH;
`else
                owner = (r != 4'b0000) ? rrPick(r, rrPtr) : -1;
`endif
            end
        end
    endtask

    task automatic checkModel();
        logic [3:0] expGrant;
        bit         anyValid;
        expGrant = (owner >= 0) ? 4'(1 << owner) : 4'b0000;
        anyValid = 1'b0;
        foreach (pipe[i]) if (pipe[i].v) anyValid = 1'b1;
        checkOutput("grant",     32'(bus.grant),     32'(expGrant));
        checkOutput("out_valid", 32'(bus.out_valid), 32'(pipe[0].v));
        checkOutput("out_bit",   32'(bus.out_bit),   32'(pipe[0].b));
        checkOutput("out_id",    32'(bus.out_id),    32'(pipe[0].id));
        checkOutput("busy",      32'(bus.busy),      32'(owner >= 0 || flushLeft > 0 || anyValid));
    endtask

    // Called at a falling edge: drive, check link_in, clock once, check outputs.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d);
        bus.req     = r;
        bus.data_in = d;
        #1;
        checkOutput("link_in", 32'(bus.link_in), 32'((owner >= 0) ? d[owner] : 1'b0));
        @(posedge clk);
        modelStep(r, d);
        @(negedge clk);
        checkModel();
    endtask

    task automatic doReset();
        rst_n       = 1'b0;
        bus.req     = '0;
        bus.data_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        modelReset();
    endtask

    initial begin
        logic [3:0] randReq;

        bus.req     = 4'b1111;
        bus.data_in = 4'b1111;
        modelReset();

        // Reset held with every requester asking.
        repeat (2) @(negedge clk);
        checkOutput("rst_grant",     32'(bus.grant),     32'(0));
        checkOutput("rst_link_in",   32'(bus.link_in),   32'(0));
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'(0));
        checkOutput("rst_out_id",    32'(bus.out_id),    32'(0));
        checkOutput("rst_busy",      32'(bus.busy),      32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("first_grant", 32'(bus.grant), 32'(4'b0001));

`ifndef DFF_LINK_ARB_FLUSH_EN
        // Single requester burst, direct regrant, then request drop.
        vecs[0]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[1]  = '{4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[2]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[3]  = '{4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[4]  = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1};
        vecs[5]  = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b1};
        vecs[6]  = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1};
        vecs[7]  = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1};
        vecs[8]  = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b1};
        vecs[9]  = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b1};
        vecs[10] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b1};
        vecs[11] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b1};
        vecs[12] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b1};
        vecs[13] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[14] = '{4'b0011, 4'b0011, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[15] = '{4'b0011, 4'b0001, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b1};

        doReset();
        for (int i = 0; i < 16; i++) begin
            bus.req     = vecs[i].req;
            bus.data_in = vecs[i].data;
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_grant", i), 32'(bus.grant),     32'(vecs[i].expGrant));
            checkOutput($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d_bit", i),   32'(bus.out_bit),   32'(vecs[i].expBit));
            checkOutput($sformatf("vec%0d_id", i),    32'(bus.out_id),    32'(vecs[i].expId));
            checkOutput($sformatf("vec%0d_busy", i),  32'(bus.busy),      32'(vecs[i].expBusy));
        end
`endif

        // Every requester asking continuously.
        doReset();
        for (int i = 0; i < 48; i++) applyStimulus(4'b1111, 4'($urandom));

        // Two requesters, exercises flush spacing when that build option is on.
        doReset();
        for (int i = 0; i < 40; i++) applyStimulus(4'b0011, 4'($urandom));

        // Reset dropped mid-burst with bits in flight.
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(4'b0001, 4'b1111);
        checkOutput("pre_rst_valid", 32'(bus.out_valid), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'(0));
        checkOutput("midrst_grant",     32'(bus.grant),     32'(0));
        checkOutput("midrst_busy",      32'(bus.busy),      32'(0));
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b0011, 4'b1111);
        checkOutput("post_rst_grant", 32'(bus.grant), 32'(4'b0001));
        for (int i = 0; i < 12; i++) applyStimulus(4'b0011, 4'b1111);

        // Randomized request patterns with long-ish holding runs.
        doReset();
        randReq = 4'($urandom);
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < N_REQ; b++) begin
                if ($urandom_range(0, 7) == 0) randReq[b] = ~randReq[b];
            end
            if ($urandom_range(0, 63) == 0) randReq = 4'b1111;
            applyStimulus(randReq, 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dff_link_arbiter.md
# dff_link_arbiter

Round-robin arbiter and sequencer that shares one DFF_link_4-style serial delay line among N_REQ bit-serial requesters. It grants the link to one requester at a time in bounded bursts and drives the link input. It tracks every bit in flight with a shadow valid/ID pipeline, so each bit leaving the link carries its owner's ID. It sits between the requester front-ends and the shared link instance.

## Interface
- N_REQ, 4, number of requesters (2..16)
- DEPTH, 4, number of DFF stages in the shared link; must match the instantiated link
- BURST_MAX, 8, maximum transfers per grant (≥1)
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-low; the same net also resets the link instance
- req  in  N_REQ  per-requester request; one bit offered per cycle while high
- data_in  in  N_REQ  per-requester serial data bit
- grant  out  N_REQ  one-hot grant, registered
- link_in  out  1  to link input_data
- link_out  in  1  from link output_data
- out_valid  out  1  out_bit/out_id carry a real bit
- out_bit  out  1  link_out gated by out_valid (0 when invalid)
- out_id  out  clog2(N_REQ)  owner of out_bit
- busy  out  1  state ≠ IDLE or any shadow valid set

## Operation
- **Reset values:** grant=0, link_in=0, out_valid=0, out_bit=0, out_id=0, busy=0. The shadow pipeline is cleared. The RR pointer is set to N_REQ-1, so requester 0 wins first. The burst counter is 0.
- **States:**
  - IDLE: grant=0. At any edge with req≠0, the RR pick becomes the new grant; go to GRANT.
  - GRANT: grant[g]=1 for the whole burst.
  - FLUSH: exists only with the macro below.
- **Transfer:** occurs at an edge where grant[g]&&req[g]. link_in = data_in[g] combinationally while granted, else 0. At the same edge, shadow stage 0 captures valid=1 and id=g. Non-transfer edges shift valid=0 into the shadow.
- **Burst end:** at the edge where the BURST_MAX-th transfer occurs, or at the first granted edge with req[g]=0. That non-transfer edge costs one bubble cycle.
- **At burst end:** the pointer is set to g. The next RR pick is evaluated on the current req vector at that same edge, searching from pointer+1 and wrapping. The previous owner may be regranted only if no other requester is pending. If req=0, go to IDLE with grant=0.
- **Counter:** width clog2(BURST_MAX+1). It clears on every new grant and saturates by construction.
- **Shadow pipeline:** DEPTH stages of {valid, id}, shifted every cycle. Stage DEPTH-1 drives out_valid and out_id.
- **Mid-burst reset:** all state clears at once (asynchronously); bits in flight are discarded, and out_valid drops immediately.

## Timing
- Grant latency: req seen at edge k (IDLE) → grant high after edge k.
- Bit transferred at edge k → on out_bit/out_valid/out_id after edge k+DEPTH-1, i.e. DEPTH-1 cycles later, aligned with link_out.
- Back-to-back bursts (macro off): zero grant gap on a BURST_MAX end; one bubble on a req-drop end.
- Simultaneous req rise of several requesters: strict RR order from pointer+1.

## Configuration
- DFF_LINK_ARB_FLUSH_EN defined:
  - Every burst end enters FLUSH instead of regranting.
  - In FLUSH, grant=0 and link_in=0 for DEPTH cycles (counter reused), then go to IDLE.
  - Result: each requester's bits exit the link as a contiguous run separated by ≥DEPTH invalid cycles.
- DFF_LINK_ARB_FLUSH_EN undefined: FLUSH is absent; regrant is direct as described above.

## Structure
- Package dff_link_arb_pkg: state enum {IDLE, GRANT, FLUSH}, ID width function (clog2).
- Sub-module dff_link_arb_rr: combinational round-robin picker. Inputs: req vector and pointer. Outputs: one-hot pick and any.
- The shadow pipeline and FSM are inline in dff_link_arbiter. The link itself is instantiated by the integrator, not inside this block.

## Test plan
- **Reset:** RST=0 with req=4'b1111 → grant=0, link_in=0, out_valid=0. Release RST → grant=4'b0001 after the first edge.
- **Single requester:** req=4'b0100 held, data 1,0,1,1,0,0,1,0 → grant=4'b0100 for 8 transfers and is regranted with no gap. out_id=2 and out_bit reproduces 10110010, starting DEPTH-1 cycles after the first transfer edge.
- **All requesters:** all 4 requesting → bursts in order 0,1,2,3,0, each exactly 8 transfers. out_valid is continuous and out_id follows the order with DEPTH-1 lag.
- **Request drop:** req[1] drops after 3 transfers → grant ends at the next edge. Exactly 3 valid outputs carry id 1, followed by a one-cycle out_valid gap before the next owner's bits.
- **Flush (DFF_LINK_ARB_FLUSH_EN):** req=4'b0011 → after burst 0, grant=0 for DEPTH cycles and out_valid low for ≥DEPTH cycles between the id-0 and id-1 runs.
- **Mid-burst reset:** RST low mid-burst with 4 bits in flight → out_valid=0 immediately. After release, grant restarts with requester 0 and no stale bits emerge.
